// File: rtl/bignum_chunk_serializer.sv
// Splits a wide operand into CHUNK_SIZE chunks, LS chunk first; one-cycle load latency, one chunk per cycle.
// Backpressure: the current chunk and its tags are held while downstream_ready_in is low; loads are refused while streaming.
module bignum_chunk_serializer #(
  parameter int TOTAL_BITS = 4096,
  parameter int CHUNK_SIZE = 32,
  localparam int NUM_CHUNKS = TOTAL_BITS / CHUNK_SIZE,
  localparam int INDEX_WIDTH = $clog2(NUM_CHUNKS)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [TOTAL_BITS-1:0]  data_in,
  input  logic                   data_valid_in,
  output logic                   ready_out,
  input  logic                   downstream_ready_in,
  output logic [CHUNK_SIZE-1:0]  chunk_out,
  output logic                   chunk_valid_out,
  output logic                   chunk_last_out,
  output logic [INDEX_WIDTH-1:0] chunk_index_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_CHUNKS - 1);

  logic [0:0]             state;
  logic [TOTAL_BITS-1:0]  shift_reg;
  logic [INDEX_WIDTH-1:0] index;
  logic                   load;
  logic                   xfer;
  logic                   at_last;

  // Every output is a decode of registers; the shift register is zero in IDLE,
  // so chunk_out reads 0 there without extra muxing.
  assign ready_out       = (state == IDLE);
  assign chunk_valid_out = (state == SEND);
  assign chunk_out       = shift_reg[CHUNK_SIZE-1:0];
  assign chunk_index_out = index;
  assign at_last         = (index == LAST_IDX);
  assign chunk_last_out  = chunk_valid_out && at_last;

  assign load = data_valid_in && ready_out;
  assign xfer = chunk_valid_out && downstream_ready_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      shift_reg <= '0;
      index     <= '0;
    end else if (load) begin
      state     <= SEND;
      shift_reg <= data_in;
      index     <= '0;
    end else if (xfer) begin
      if (at_last) begin
        state     <= IDLE;
        shift_reg <= '0;
        index     <= '0;
      end else begin
        shift_reg <= shift_reg >> CHUNK_SIZE;
        index     <= index + 1'b1;
      end
    end
  end

endmodule
